// File: rtl/pll_reset_seq.sv
// Lock supervisor for an ECP5 PLL: retries the PLL on lock timeout and releases a
// staged active-low reset bundle once lock has been stable long enough.
module pll_reset_seq #(
  parameter int SYNC_STAGES    = 2,
  parameter int STABLE_CYCLES  = 1024,
  parameter int NUM_STAGES     = 3,
  parameter int STAGE_GAP      = 16,
  parameter int LOCK_TIMEOUT   = 65536,
  parameter int PLL_RST_CYCLES = 32,
  parameter int CNT_W          = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  lockedn_in,
  input  logic                  soft_rst,
  output logic                  pll_rst,
  output logic [NUM_STAGES-1:0] rstn_out,
  output logic                  ready,
  output logic [CNT_W-1:0]      lock_loss_cnt,
  output logic [CNT_W-1:0]      timeout_cnt
);

  localparam int STAB_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int TO_W   = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam int PR_W   = (PLL_RST_CYCLES > 1) ? $clog2(PLL_RST_CYCLES) : 1;
  localparam int GAP_W  = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
  localparam int IDX_W  = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(LOCK_TIMEOUT - 1);
  localparam logic [PR_W-1:0]   PR_LAST   = PR_W'(PLL_RST_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(STAGE_GAP - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_STAGES - 1);

  typedef enum logic [1:0] {
    S_WAIT_LOCK,
    S_PLL_RESET,
    S_RELEASE,
    S_RUN
  } state_t;

  state_t                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    lock_s;
  logic [STAB_W-1:0]       stab_q, stab_d;
  logic [TO_W-1:0]         to_q, to_d;
  logic [PR_W-1:0]         prc_q, prc_d;
  logic [GAP_W-1:0]        gap_q, gap_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    pll_rst_q, pll_rst_d;
  logic [NUM_STAGES-1:0]   rstn_q, rstn_d;
  logic                    ready_q, ready_d;
  logic [CNT_W-1:0]        llc_q, llc_d;
  logic [CNT_W-1:0]        tcnt_q, tcnt_d;

  // Synchronizer presets to "unlocked" so nothing is released straight out of reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], lockedn_in};
    end
  end

  assign lock_s = ~sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_WAIT_LOCK;
      stab_q    <= '0;
      to_q      <= '0;
      prc_q     <= '0;
      gap_q     <= '0;
      idx_q     <= '0;
      pll_rst_q <= 1'b0;
      rstn_q    <= '0;
      ready_q   <= 1'b0;
      llc_q     <= '0;
      tcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      stab_q    <= stab_d;
      to_q      <= to_d;
      prc_q     <= prc_d;
      gap_q     <= gap_d;
      idx_q     <= idx_d;
      pll_rst_q <= pll_rst_d;
      rstn_q    <= rstn_d;
      ready_q   <= ready_d;
      llc_q     <= llc_d;
      tcnt_q    <= tcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stab_d  = stab_q;
    to_d    = to_q;
    prc_d   = prc_q;
    gap_d   = gap_q;
    idx_d   = idx_q;
    rstn_d  = rstn_q;
    llc_d   = llc_q;
    tcnt_d  = tcnt_q;

    unique case (state_q)
      S_WAIT_LOCK: begin
        to_d = to_q + 1'b1;
        if (lock_s && !soft_rst) begin
          if (stab_q == STAB_LAST) begin
            state_d = S_RELEASE;
            idx_d   = '0;
            gap_d   = '0;
          end else begin
            stab_d = stab_q + 1'b1;
          end
        end else begin
          stab_d = '0;
        end
        // A release decided in the same cycle takes precedence over the timeout.
        if (state_d == S_WAIT_LOCK && to_q == TO_LAST) begin
          state_d = S_PLL_RESET;
          prc_d   = '0;
          tcnt_d  = (tcnt_q == {CNT_W{1'b1}}) ? tcnt_q : tcnt_q + 1'b1;
        end
      end

      S_PLL_RESET: begin
        if (prc_q == PR_LAST) begin
          state_d = S_WAIT_LOCK;
          stab_d  = '0;
          to_d    = '0;
        end else begin
          prc_d = prc_q + 1'b1;
        end
      end

      S_RELEASE, S_RUN: begin
        if (!lock_s || soft_rst) begin
          state_d = S_WAIT_LOCK;
          stab_d  = '0;
          to_d    = '0;
          rstn_d  = '0;
          if (!lock_s) begin
            llc_d = (llc_q == {CNT_W{1'b1}}) ? llc_q : llc_q + 1'b1;
          end
        end else if (state_q == S_RELEASE) begin
          if (gap_q == '0) begin
            rstn_d[idx_q] = 1'b1;
            if (idx_q == IDX_LAST) begin
              state_d = S_RUN;
            end else begin
              idx_d = idx_q + 1'b1;
              gap_d = GAP_LOAD;
            end
          end else begin
            gap_d = gap_q - 1'b1;
          end
        end
      end

      default: state_d = S_WAIT_LOCK;
    endcase

    pll_rst_d = (state_d == S_PLL_RESET);
    ready_d   = (state_q == S_RUN) && (state_d == S_RUN);
  end

  assign pll_rst       = pll_rst_q;
  assign rstn_out      = rstn_q;
  assign ready         = ready_q;
  assign lock_loss_cnt = llc_q;
  assign timeout_cnt   = tcnt_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Bench for pll_reset_seq: timestamp-based reference model checked every cycle,
// plus scenario latency checks derived arithmetically from the lock/release rules.
module tb_pll_reset_seq;

  localparam int SYNC   = 2;
  localparam int STABLE = 8;
  localparam int NUM    = 3;
  localparam int GAP    = 4;
  localparam int TMO    = 64;
  localparam int PRC    = 5;
  localparam int CW     = 8;
  localparam int SAT    = (1 << CW) - 1;
  localparam int HIST   = 30000;

  localparam int PH_WAIT = 0;
  localparam int PH_PLL  = 1;
  localparam int PH_REL  = 2;
  localparam int PH_RUN  = 3;

  logic            clk = 1'b0;
  logic            rstn;
  logic            lockedn_in;
  logic            soft_rst;
  logic            pll_rst;
  logic [NUM-1:0]  rstn_out;
  logic            ready;
  logic [CW-1:0]   lock_loss_cnt;
  logic [CW-1:0]   timeout_cnt;

  pll_reset_seq #(
    .SYNC_STAGES(SYNC), .STABLE_CYCLES(STABLE), .NUM_STAGES(NUM), .STAGE_GAP(GAP),
    .LOCK_TIMEOUT(TMO), .PLL_RST_CYCLES(PRC), .CNT_W(CW)
  ) dut (
    .clk(clk), .rstn(rstn), .lockedn_in(lockedn_in), .soft_rst(soft_rst),
    .pll_rst(pll_rst), .rstn_out(rstn_out), .ready(ready),
    .lock_loss_cnt(lock_loss_cnt), .timeout_cnt(timeout_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int t_release;

  bit lkn_hist  [0:HIST-1];
  bit soft_hist [0:HIST-1];

  // Model: phase plus the edge at which it was entered; outputs follow from elapsed time.
  int m_phase, m_t0, m_stab, m_rel, m_llc, m_tcnt;
  logic           exp_pll, exp_ready;
  logic [NUM-1:0] exp_rstn;
  logic [CW-1:0]  exp_llc, exp_tcnt;

  function automatic void model_reset(int r);
    m_phase = PH_WAIT; m_t0 = r; m_stab = -1; m_rel = r; m_llc = 0; m_tcnt = 0;
  endfunction

  function automatic void model_step(int t);
    bit lk, sf, ok;
    lk = (t - SYNC >= m_rel) ? !lkn_hist[t-SYNC] : 1'b0;
    sf = soft_hist[t];
    case (m_phase)
      PH_WAIT: begin
        ok = lk && !sf;
        if (!ok) m_stab = -1;
        else if (m_stab < 0) m_stab = t;
        if (ok && (t - m_stab + 1 == STABLE)) begin
          m_phase = PH_REL; m_t0 = t + 1;
        end else if (t - m_t0 + 1 == TMO) begin
          m_phase = PH_PLL; m_t0 = t + 1;
          if (m_tcnt < SAT) m_tcnt++;
        end
      end
      PH_PLL: begin
        if (t - m_t0 + 1 == PRC) begin
          m_phase = PH_WAIT; m_t0 = t + 1; m_stab = -1;
        end
      end
      default: begin
        if (!lk || sf) begin
          if (!lk && m_llc < SAT) m_llc++;
          m_phase = PH_WAIT; m_t0 = t + 1; m_stab = -1;
        end else if (m_phase == PH_REL && (t - m_t0 == (NUM - 1) * GAP)) begin
          m_phase = PH_RUN; m_t0 = t + 1;
        end
      end
    endcase
  endfunction

  function automatic void model_outputs(int e);
    int k;
    exp_pll   = (m_phase == PH_PLL);
    exp_ready = (m_phase == PH_RUN) && (e > m_t0);
    exp_rstn  = '0;
    if (m_phase == PH_RUN) begin
      exp_rstn = '1;
    end else if (m_phase == PH_REL && e > m_t0) begin
      k = (e - m_t0 - 1) / GAP + 1;
      if (k > NUM) k = NUM;
      exp_rstn = NUM'((1 << k) - 1);
    end
    exp_llc  = CW'(m_llc);
    exp_tcnt = CW'(m_tcnt);
  endfunction

  task automatic tick();
    bit rst_now;
    if (cyc >= HIST - 1) begin
      $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, HIST - 1);
      $fatal(1);
    end
    lkn_hist[cyc]  = lockedn_in;
    soft_hist[cyc] = soft_rst;
    rst_now = !rstn;
    @(posedge clk);
    #1;
    if (rst_now) model_reset(cyc + 1);
    else model_step(cyc);
    cyc++;
    model_outputs(cyc);
  endtask

  task automatic test_reset();
    rstn = 1'b0; lockedn_in = 1'b1; soft_rst = 1'b0;
    repeat (3) begin
      tick();
      if ({pll_rst, rstn_out, ready, lock_loss_cnt, timeout_cnt} !== {exp_pll, exp_rstn, exp_ready, exp_llc, exp_tcnt}) begin
        fails++;
        $display("FAIL reset_model cyc=%0d got %b/%b/%b/%0d/%0d want %b/%b/%b/%0d/%0d", cyc, pll_rst, rstn_out, ready, lock_loss_cnt, timeout_cnt, exp_pll, exp_rstn, exp_ready, exp_llc, exp_tcnt);
      end
      checks++;
    end
    if ({pll_rst, rstn_out, ready, lock_loss_cnt, timeout_cnt} !== '0) begin
      fails++;
      $display("FAIL reset_values got pll=%b rstn=%b rdy=%b llc=%0d tc=%0d want all zero", pll_rst, rstn_out, ready, lock_loss_cnt, timeout_cnt);
    end
    checks++;
    rstn = 1'b1;
    t_release = cyc;
    $display("reset: released at cycle %0d", t_release);
  endtask

  task automatic test_timeout();
    int rises = 0, rise_at = -1, exp_r;
    bit prev = 1'b0;
    lockedn_in = 1'b1;
    for (int i = 0; i < 205; i++) begin
      tick();
      if ({pll_rst, rstn_out, ready, lock_loss_cnt, timeout_cnt} !== {exp_pll, exp_rstn, exp_ready, exp_llc, exp_tcnt}) begin
        fails++;
        $display("FAIL timeout_model cyc=%0d got %b/%b/%b/%0d/%0d want %b/%b/%b/%0d/%0d", cyc, pll_rst, rstn_out, ready, lock_loss_cnt, timeout_cnt, exp_pll, exp_rstn, exp_ready, exp_llc, exp_tcnt);
      end
      checks++;
      if (pll_rst && !prev) begin
        exp_r = t_release + TMO + rises * (TMO + PRC);
        if (cyc !== exp_r) begin
          fails++;
          $display("FAIL timeout_rise got cycle %0d want %0d", cyc, exp_r);
        end
        checks++;
        rise_at = cyc; rises++;
      end
      if (!pll_rst && prev) begin
        if (cyc - rise_at !== PRC) begin
          fails++;
          $display("FAIL pll_rst_width got %0d want %0d", cyc - rise_at, PRC);
        end
        checks++;
      end
      prev = pll_rst;
      if (cyc - t_release == 140) begin
        if (timeout_cnt !== 8'd2) begin
          fails++;
          $display("FAIL timeout_cnt_140 got %0d want 2", timeout_cnt);
        end
        checks++;
      end
    end
    if (timeout_cnt !== 8'd3 || rstn_out !== '0) begin
      fails++;
      $display("FAIL timeout_end got tc=%0d rstn=%b want tc=3 rstn=000", timeout_cnt, rstn_out);
    end
    checks++;
    $display("timeout: %0d PLL reset pulses seen", rises);
  endtask

  task automatic test_clean_lock();
    int d = -1, rr = -1, want;
    int r [NUM];
    for (int b = 0; b < NUM; b++) r[b] = -1;
    for (int i = 0; i < 40; i++) begin
      if (i == 10) begin lockedn_in = 1'b0; d = cyc; end
      tick();
      if ({pll_rst, rstn_out, ready, lock_loss_cnt, timeout_cnt} !== {exp_pll, exp_rstn, exp_ready, exp_llc, exp_tcnt}) begin
        fails++;
        $display("FAIL clean_model cyc=%0d got %b/%b/%b/%0d/%0d want %b/%b/%b/%0d/%0d", cyc, pll_rst, rstn_out, ready, lock_loss_cnt, timeout_cnt, exp_pll, exp_rstn, exp_ready, exp_llc, exp_tcnt);
      end
      checks++;
      for (int b = 0; b < NUM; b++) if (rstn_out[b] && r[b] < 0) r[b] = cyc;
      if (ready && rr < 0) rr = cyc;
    end
    for (int b = 0; b < NUM; b++) begin
      want = d + SYNC + STABLE + 1 + b * GAP;
      if (r[b] !== want) begin
        fails++;
        $display("FAIL clean_bit%0d_rise got cycle %0d want %0d", b, r[b], want);
      end
      checks++;
    end
    want = d + SYNC + STABLE + 1 + (NUM - 1) * GAP + 1;
    if (rr !== want || lock_loss_cnt !== 8'd0) begin
      fails++;
      $display("FAIL clean_ready got ready_at=%0d llc=%0d want ready_at=%0d llc=0", rr, lock_loss_cnt, want);
    end
    checks++;
    $display("clean_lock: drop at %0d, bit0 at %0d, ready at %0d", d, r[0], rr);
  endtask

  task automatic test_lock_loss_run();
    int up, low, lost = -1, back = -1, want;
    repeat ($urandom_range(1, 10)) begin
      tick();
      if ({pll_rst, rstn_out, ready, lock_loss_cnt, timeout_cnt} !== {exp_pll, exp_rstn, exp_ready, exp_llc, exp_tcnt}) begin
        fails++;
        $display("FAIL loss_hold_model cyc=%0d got %b/%b/%b/%0d/%0d want %b/%b/%b/%0d/%0d", cyc, pll_rst, rstn_out, ready, lock_loss_cnt, timeout_cnt, exp_pll, exp_rstn, exp_ready, exp_llc, exp_tcnt);
      end
      checks++;
    end
    lockedn_in = 1'b1; up = cyc;
    tick();
    lockedn_in = 1'b0; low = cyc;
    for (int i = 0; i < 40; i++) begin
      tick();
      if ({pll_rst, rstn_out, ready, lock_loss_cnt, timeout_cnt} !== {exp_pll, exp_rstn, exp_ready, exp_llc, exp_tcnt}) begin
        fails++;
        $display("FAIL loss_model cyc=%0d got %b/%b/%b/%0d/%0d want %b/%b/%b/%0d/%0d", cyc, pll_rst, rstn_out, ready, lock_loss_cnt, timeout_cnt, exp_pll, exp_rstn, exp_ready, exp_llc, exp_tcnt);
      end
      checks++;
      if (lost < 0 && rstn_out == '0 && !ready) lost = cyc;
      if (lost >= 0 && back < 0 && rstn_out[0]) back = cyc;
    end
    if (lost < 0 || lost - up > SYNC + 1 || lock_loss_cnt !== 8'd1) begin
      fails++;
      $display("FAIL loss_detect got drop_after=%0d llc=%0d want drop_after<=%0d llc=1", lost - up, lock_loss_cnt, SYNC + 1);
    end
    checks++;
    want = low + SYNC + STABLE + 1;
    if (back !== want || ready !== 1'b1) begin
      fails++;
      $display("FAIL loss_resequence got bit0_at=%0d ready=%b want bit0_at=%0d ready=1", back, ready, want);
    end
    checks++;
    $display("lock_loss_run: loss at %0d, outputs dropped at %0d, bit0 back at %0d", up, lost, back);
  endtask

  task automatic test_glitchy();
    int f, r0 = -1, want;
    lockedn_in = 1'b1;
    for (int i = 0; i < 19; i++) begin
      if (i == 6) lockedn_in = 1'b0;
      if (i == 11) lockedn_in = 1'b1;
      if (i == 12) lockedn_in = 1'b0;
      tick();
      if ({pll_rst, rstn_out, ready, lock_loss_cnt, timeout_cnt} !== {exp_pll, exp_rstn, exp_ready, exp_llc, exp_tcnt}) begin
        fails++;
        $display("FAIL glitch_pre_model cyc=%0d got %b/%b/%b/%0d/%0d want %b/%b/%b/%0d/%0d", cyc, pll_rst, rstn_out, ready, lock_loss_cnt, timeout_cnt, exp_pll, exp_rstn, exp_ready, exp_llc, exp_tcnt);
      end
      checks++;
    end
    f = cyc - 7;
    for (int i = 0; i < 6; i++) begin
      tick();
      if ({pll_rst, rstn_out, ready, lock_loss_cnt, timeout_cnt} !== {exp_pll, exp_rstn, exp_ready, exp_llc, exp_tcnt} || pll_rst !== 1'b0) begin
        fails++;
        $display("FAIL glitch_model cyc=%0d got %b/%b/%b/%0d/%0d want %b/%b/%b/%0d/%0d", cyc, pll_rst, rstn_out, ready, lock_loss_cnt, timeout_cnt, exp_pll, exp_rstn, exp_ready, exp_llc, exp_tcnt);
      end
      checks++;
      if (rstn_out[0] && r0 < 0) r0 = cyc;
    end
    want = f + SYNC + STABLE + 1;
    if (r0 !== want) begin
      fails++;
      $display("FAIL glitch_bit0_rise got cycle %0d want %0d", r0, want);
    end
    checks++;
    $display("glitchy: final drop at %0d, bit0 at %0d", f, r0);
  endtask

  task automatic test_soft_rst();
    int s, r0 = -1, want;
    repeat ($urandom_range(0, 1)) begin
      tick();
      if ({pll_rst, rstn_out, ready, lock_loss_cnt, timeout_cnt} !== {exp_pll, exp_rstn, exp_ready, exp_llc, exp_tcnt}) begin
        fails++;
        $display("FAIL soft_pre_model cyc=%0d got %b/%b/%b/%0d/%0d want %b/%b/%b/%0d/%0d", cyc, pll_rst, rstn_out, ready, lock_loss_cnt, timeout_cnt, exp_pll, exp_rstn, exp_ready, exp_llc, exp_tcnt);
      end
      checks++;
    end
    soft_rst = 1'b1; s = cyc;
    tick();
    soft_rst = 1'b0;
    if (rstn_out !== '0 || ready !== 1'b0 || lock_loss_cnt !== 8'd2) begin
      fails++;
      $display("FAIL soft_drop got rstn=%b rdy=%b llc=%0d want rstn=000 rdy=0 llc=2", rstn_out, ready, lock_loss_cnt);
    end
    checks++;
    for (int i = 0; i < 20; i++) begin
      tick();
      if ({pll_rst, rstn_out, ready, lock_loss_cnt, timeout_cnt} !== {exp_pll, exp_rstn, exp_ready, exp_llc, exp_tcnt}) begin
        fails++;
        $display("FAIL soft_model cyc=%0d got %b/%b/%b/%0d/%0d want %b/%b/%b/%0d/%0d", cyc, pll_rst, rstn_out, ready, lock_loss_cnt, timeout_cnt, exp_pll, exp_rstn, exp_ready, exp_llc, exp_tcnt);
      end
      checks++;
      if (rstn_out[0] && r0 < 0) r0 = cyc;
    end
    want = s + 1 + STABLE + 1;
    if (r0 !== want) begin
      fails++;
      $display("FAIL soft_restart_bit0 got cycle %0d want %0d", r0, want);
    end
    checks++;
    $display("soft_rst: request at %0d, bit0 again at %0d", s, r0);
  endtask

  task automatic test_random();
    int n = 0, len;
    while (n < 1500) begin
      lockedn_in = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 90);
      repeat (len) begin
        soft_rst = ($urandom_range(0, 39) == 0);
        tick();
        if ({pll_rst, rstn_out, ready, lock_loss_cnt, timeout_cnt} !== {exp_pll, exp_rstn, exp_ready, exp_llc, exp_tcnt}) begin
          fails++;
          $display("FAIL random_model cyc=%0d got %b/%b/%b/%0d/%0d want %b/%b/%b/%0d/%0d", cyc, pll_rst, rstn_out, ready, lock_loss_cnt, timeout_cnt, exp_pll, exp_rstn, exp_ready, exp_llc, exp_tcnt);
        end
        checks++;
        n++;
      end
    end
    soft_rst = 1'b0;
    $display("random: %0d cycles, llc=%0d tc=%0d", n, lock_loss_cnt, timeout_cnt);
  endtask

  task automatic test_saturation();
    lockedn_in = 1'b0;
    for (int i = 0; i <= 300; i++) begin
      repeat ((i == 0) ? 10 : $urandom_range(12, 30)) begin
        tick();
        if ({pll_rst, rstn_out, ready, lock_loss_cnt, timeout_cnt} !== {exp_pll, exp_rstn, exp_ready, exp_llc, exp_tcnt}) begin
          fails++;
          $display("FAIL sat_model cyc=%0d got %b/%b/%b/%0d/%0d want %b/%b/%b/%0d/%0d", cyc, pll_rst, rstn_out, ready, lock_loss_cnt, timeout_cnt, exp_pll, exp_rstn, exp_ready, exp_llc, exp_tcnt);
        end
        checks++;
      end
      if (i == 300) break;
      lockedn_in = 1'b1;
      repeat ($urandom_range(1, 3)) begin
        tick();
        if ({pll_rst, rstn_out, ready, lock_loss_cnt, timeout_cnt} !== {exp_pll, exp_rstn, exp_ready, exp_llc, exp_tcnt}) begin
          fails++;
          $display("FAIL sat_model cyc=%0d got %b/%b/%b/%0d/%0d want %b/%b/%b/%0d/%0d", cyc, pll_rst, rstn_out, ready, lock_loss_cnt, timeout_cnt, exp_pll, exp_rstn, exp_ready, exp_llc, exp_tcnt);
        end
        checks++;
      end
      lockedn_in = 1'b0;
    end
    if (lock_loss_cnt !== 8'd255) begin
      fails++;
      $display("FAIL llc_saturate got %0d want 255", lock_loss_cnt);
    end
    checks++;
    $display("saturation: lock_loss_cnt=%0d", lock_loss_cnt);
  endtask

  task automatic test_async_reset();
    bit found = 1'b0;
    lockedn_in = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if ({pll_rst, rstn_out, ready, lock_loss_cnt, timeout_cnt} !== {exp_pll, exp_rstn, exp_ready, exp_llc, exp_tcnt}) begin
        fails++;
        $display("FAIL async_pre_model cyc=%0d got %b/%b/%b/%0d/%0d want %b/%b/%b/%0d/%0d", cyc, pll_rst, rstn_out, ready, lock_loss_cnt, timeout_cnt, exp_pll, exp_rstn, exp_ready, exp_llc, exp_tcnt);
      end
      checks++;
      if (pll_rst) begin found = 1'b1; break; end
    end
    if (!found) begin
      fails++;
      $display("FAIL async_wait_pulse got no pll_rst within 200 cycles want a pulse");
    end
    checks++;
    tick();
    #2 rstn = 1'b0;
    #1;
    if ({pll_rst, rstn_out, ready, lock_loss_cnt, timeout_cnt} !== '0) begin
      fails++;
      $display("FAIL async_reset got pll=%b rstn=%b rdy=%b llc=%0d tc=%0d want all zero", pll_rst, rstn_out, ready, lock_loss_cnt, timeout_cnt);
    end
    checks++;
    repeat (2) tick();
    rstn = 1'b1;
    repeat (10) begin
      tick();
      if ({pll_rst, rstn_out, ready, lock_loss_cnt, timeout_cnt} !== {exp_pll, exp_rstn, exp_ready, exp_llc, exp_tcnt}) begin
        fails++;
        $display("FAIL async_post_model cyc=%0d got %b/%b/%b/%0d/%0d want %b/%b/%b/%0d/%0d", cyc, pll_rst, rstn_out, ready, lock_loss_cnt, timeout_cnt, exp_pll, exp_rstn, exp_ready, exp_llc, exp_tcnt);
      end
      checks++;
    end
    $display("async_reset: reset applied mid pll_rst pulse");
  endtask

  initial begin
    rstn = 1'b0; lockedn_in = 1'b1; soft_rst = 1'b0;
    model_reset(0);
    model_outputs(0);
    #1;
    test_reset();
    test_timeout();
    test_clean_lock();
    test_lock_loss_run();
    test_glitchy();
    test_soft_rst();
    test_random();
    test_saturation();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
